// File: rtl/mem_lsu_pkg.sv
// Shared encodings for the MEM-stage load/store unit.
// Ops, error codes, FSM states and the alignment check.
package mem_lsu_pkg;

  typedef enum logic [2:0] {
    OP_LW  = 3'd0,
    OP_LH  = 3'd1,
    OP_LHU = 3'd2,
    OP_LB  = 3'd3,
    OP_LBU = 3'd4,
    OP_SW  = 3'd5,
    OP_SH  = 3'd6,
    OP_SB  = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ERR_OK      = 2'd0,
    ERR_ALIGN   = 2'd1,
    ERR_RANGE   = 2'd2,
    ERR_TIMEOUT = 2'd3
  } err_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2
  } state_e;

  function automatic logic misaligned(
    input op_e        o,
    input logic [1:0] a
  );
    logic m;
    m = 1'b0;
    unique case (1'b1)
      (o == OP_LW || o == OP_SW): m = (a != 2'b00);
      (o == OP_LH || o == OP_LHU ||
       o == OP_SH):               m = a[0];
      default:                    m = 1'b0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/mem_lsu_if.sv
// Data-memory word port between the LSU (master)
// and the memory (slave).
interface mem_lsu_if;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_be,
    output mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_be,
    input  mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/mem_lsu_lane.sv
// Byte-lane steering: store enables/replication and
// load extraction with sign/zero extension.
module lsu_lane
  import mem_lsu_pkg::*;
(
  input  op_e         op,
  input  logic [1:0]  lane,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wrep,
  output logic [31:0] ldata
);

  logic [7:0]  rb;
  logic [15:0] rh;

  assign rb = 8'(rword >> {lane, 3'b000});
  assign rh = lane[1] ? rword[31:16] : rword[15:0];

  always_comb begin
    be    = 4'b1111;
    wrep  = wdata;
    ldata = rword;
    unique case (1'b1)
      (op == OP_SH): begin
        be   = 4'b0011 << lane;
        wrep = {2{wdata[15:0]}};
      end
      (op == OP_SB): begin
        be   = 4'b0001 << lane;
        wrep = {4{wdata[7:0]}};
      end
      (op == OP_LH):  ldata = {{16{rh[15]}}, rh};
      (op == OP_LHU): ldata = {16'h0, rh};
      (op == OP_LB):  ldata = {{24{rb[7]}}, rb};
      (op == OP_LBU): ldata = {24'h0, rb};
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// MEM-stage load/store initiator with req/ack memory port.
// Define MEM_LSU_TRACE_EN to print completed stores.
module mem_lsu
  import mem_lsu_pkg::*;
#(
  parameter int DM_WORDS = 3072,
  parameter int TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [31:0] pc,
  output logic        out_valid,
  output logic [31:0] rdata,
  output logic [1:0]  err,
  mem_lsu_if.master   mem
);

  localparam logic [31:0] DM_BYTES = 32'(4 * DM_WORDS);
  localparam logic [7:0]  CNT_LAST = 8'(TIMEOUT - 1);

  state_e      state_q, state_d;
  op_e         op_q, op_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  err_e        err_q, err_d;
  logic [7:0]  cnt_q, cnt_d;

  logic [3:0]  be;
  logic [31:0] wrep;
  logic [31:0] ldata;
  logic        in_req;
  logic        is_st;

  lsu_lane u_lane (
    .op    (op_q),
    .lane  (addr_q[1:0]),
    .wdata (wdata_q),
    .rword (mem.mem_rdata),
    .be    (be),
    .wrep  (wrep),
    .ldata (ldata)
  );

  assign in_req = (state_q == S_REQ);
  assign is_st  = (op_q >= OP_SW);

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          op_d    = op_e'(op);
          addr_d  = addr;
          wdata_d = wdata;
          rdata_d = '0;
          cnt_d   = '0;
          if (misaligned(op_e'(op), addr[1:0])) begin
            err_d   = ERR_ALIGN;
            state_d = S_RESP;
          end else if (addr >= DM_BYTES) begin
            err_d   = ERR_RANGE;
            state_d = S_RESP;
          end else begin
            err_d   = ERR_OK;
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        if (mem.mem_ack) begin
          rdata_d = is_st ? '0 : ldata;
          state_d = S_RESP;
        end else if (cnt_q == CNT_LAST) begin
          err_d   = ERR_TIMEOUT;
          rdata_d = '0;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_RESP: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      op_q    <= OP_LW;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= ERR_OK;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_RESP);
  assign rdata     = out_valid ? rdata_q : '0;
  assign err       = out_valid ? err_q : ERR_OK;

  assign mem.mem_req   = in_req;
  assign mem.mem_we    = in_req && is_st;
  assign mem.mem_be    = in_req ? be : 4'b0000;
  assign mem.mem_addr  = in_req ? {addr_q[31:2], 2'b00} : '0;
  assign mem.mem_wdata = in_req ? wrep : '0;

`ifdef MEM_LSU_TRACE_EN
  logic [31:0] pc_q, pc_d;
  logic [31:0] word_q, word_d;
  logic [31:0] mask;
  logic [31:0] merged;

  always_comb begin
    pc_d   = pc_q;
    word_d = word_q;
    if (state_q == S_IDLE && in_valid) pc_d = pc;
    if (in_req && mem.mem_ack) word_d = mem.mem_rdata;
    mask   = {{8{be[3]}}, {8{be[2]}},
              {8{be[1]}}, {8{be[0]}}};
    merged = (wrep & mask) | (word_q & ~mask);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q   <= '0;
      word_q <= '0;
    end else begin
      pc_q   <= pc_d;
      word_q <= word_d;
      if (out_valid && is_st && err_q == ERR_OK)
        $display("%0t@%h: *%h <= %h", $time, pc_q,
                 {addr_q[31:2], 2'b00}, merged);
    end
  end
`else
  logic unused_pc;
  assign unused_pc = ^pc;
`endif

endmodule

// File: tb/tb_mem_lsu.sv
// Directed self-checking bench for mem_lsu.
// Memory side is driven by hand through the interface.
module tb_mem_lsu;

  localparam int TIMEOUT = 255;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  op;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] pc;
  logic        out_valid;
  logic [31:0] rdata;
  logic [1:0]  err;

  int total = 0;
  int bad   = 0;

  mem_lsu_if mif ();

  mem_lsu #(.DM_WORDS(3072), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .addr      (addr),
    .wdata     (wdata),
    .pc        (pc),
    .out_valid (out_valid),
    .rdata     (rdata),
    .err       (err),
    .mem       (mif)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [2:0] o,
                       input logic [31:0] a,
                       input logic [31:0] wd);
    in_valid = 1'b1;
    op       = o;
    addr     = a;
    wdata    = wd;
    pc       = 32'h0000_1000 + a;
    step();
    in_valid = 1'b0;
  endtask

  task automatic txn(input string tag,
                     input logic [2:0] o,
                     input logic [31:0] a,
                     input logic [31:0] wd,
                     input logic [31:0] rw,
                     input int dly,
                     input logic [3:0] ebe,
                     input logic [31:0] ewd,
                     input logic [31:0] erd);
    logic stable;
    drive(o, a, wd);
    stable = 1'b1;
    for (int i = 0; i < dly; i++) begin
      if (!(mif.mem_req && mif.mem_be == ebe &&
            mif.mem_addr == {a[31:2], 2'b00}))
        stable = 1'b0;
      step();
    end
    chk({tag, ".hold"}, 32'(stable), 32'd1);
    chk({tag, ".req"}, 32'(mif.mem_req), 32'd1);
    chk({tag, ".maddr"}, mif.mem_addr,
        {a[31:2], 2'b00});
    chk({tag, ".be"}, 32'(mif.mem_be), 32'(ebe));
    chk({tag, ".we"}, 32'(mif.mem_we),
        32'(o >= 3'd5));
    chk({tag, ".wdata"}, mif.mem_wdata, ewd);
    chk({tag, ".early"}, 32'(out_valid), 32'd0);
    mif.mem_ack   = 1'b1;
    mif.mem_rdata = rw;
    step();
    mif.mem_ack   = 1'b0;
    mif.mem_rdata = 32'h0;
    chk({tag, ".ov"}, 32'(out_valid), 32'd1);
    chk({tag, ".err"}, 32'(err), 32'd0);
    chk({tag, ".rdata"}, rdata, erd);
    chk({tag, ".reqoff"}, 32'(mif.mem_req), 32'd0);
    step();
    chk({tag, ".rdy"}, 32'(in_ready), 32'd1);
    chk({tag, ".ovoff"}, 32'(out_valid), 32'd0);
  endtask

  task automatic errtxn(input string tag,
                        input logic [2:0] o,
                        input logic [31:0] a,
                        input logic [1:0] eerr);
    drive(o, a, 32'hFFFF_FFFF);
    chk({tag, ".ov"}, 32'(out_valid), 32'd1);
    chk({tag, ".err"}, 32'(err), 32'(eerr));
    chk({tag, ".rdata"}, rdata, 32'h0);
    chk({tag, ".noreq"}, 32'(mif.mem_req), 32'd0);
    step();
    chk({tag, ".rdy"}, 32'(in_ready), 32'd1);
    chk({tag, ".noreq2"}, 32'(mif.mem_req), 32'd0);
  endtask

  initial begin : main
    logic stable;
    reset         = 1'b1;
    in_valid      = 1'b0;
    op            = 3'd0;
    addr          = 32'h0;
    wdata         = 32'h0;
    pc            = 32'h0;
    mif.mem_ack   = 1'b0;
    mif.mem_rdata = 32'h0;
    step();
    step();
    chk("rst.rdy", 32'(in_ready), 32'd1);
    chk("rst.ov", 32'(out_valid), 32'd0);
    chk("rst.rdata", rdata, 32'h0);
    chk("rst.err", 32'(err), 32'd0);
    chk("rst.req", 32'(mif.mem_req), 32'd0);
    chk("rst.we", 32'(mif.mem_we), 32'd0);
    chk("rst.be", 32'(mif.mem_be), 32'd0);
    chk("rst.maddr", mif.mem_addr, 32'h0);
    chk("rst.wdata", mif.mem_wdata, 32'h0);
    reset = 1'b0;
    step();

    txn("sw", 3'd5, 32'h10, 32'hDEAD_BEEF, 32'h0, 0,
        4'b1111, 32'hDEAD_BEEF, 32'h0);
    txn("sb", 3'd7, 32'h13, 32'h0000_00AB, 32'h0, 0,
        4'b1000, 32'hABAB_ABAB, 32'h0);
    txn("lb", 3'd3, 32'h13, 32'h0, 32'hAB00_0000, 0,
        4'b1111, 32'h0, 32'hFFFF_FFAB);
    txn("lbu", 3'd4, 32'h13, 32'h0, 32'hAB00_0000, 0,
        4'b1111, 32'h0, 32'h0000_00AB);
    txn("lbpos", 3'd3, 32'h11, 32'h0, 32'h0000_7F00, 0,
        4'b1111, 32'h0, 32'h0000_007F);
    txn("lh", 3'd1, 32'h22, 32'h0, 32'h8001_0000, 0,
        4'b1111, 32'h0, 32'hFFFF_8001);
    txn("lhu", 3'd2, 32'h22, 32'h0, 32'h8001_0000, 0,
        4'b1111, 32'h0, 32'h0000_8001);
    txn("sh", 3'd6, 32'h22, 32'h5555_1234, 32'h0, 0,
        4'b1100, 32'h1234_1234, 32'h0);
    txn("lwtop", 3'd0, 32'h2FFC, 32'h0, 32'h1122_3344, 0,
        4'b1111, 32'h0, 32'h1122_3344);
    txn("lwdly", 3'd0, 32'h100, 32'h0, 32'hCAFE_F00D, 5,
        4'b1111, 32'h0, 32'hCAFE_F00D);

    errtxn("lwmis", 3'd0, 32'h6, 2'd1);
    errtxn("shmis", 3'd6, 32'h21, 2'd1);
    errtxn("lhmisrng", 3'd1, 32'h3001, 2'd1);
    errtxn("swrng", 3'd5, 32'h3000, 2'd2);

    drive(3'd0, 32'h40, 32'h0);
    chk("to.busy", 32'(in_ready), 32'd0);
    stable = 1'b1;
    for (int i = 0; i < TIMEOUT - 1; i++) begin
      if (!(mif.mem_req && !mif.mem_we &&
            mif.mem_be == 4'b1111 &&
            mif.mem_addr == 32'h40 && !out_valid))
        stable = 1'b0;
      step();
    end
    chk("to.hold", 32'(stable), 32'd1);
    chk("to.lastreq", 32'(mif.mem_req), 32'd1);
    step();
    chk("to.ov", 32'(out_valid), 32'd1);
    chk("to.err", 32'(err), 32'd3);
    chk("to.rdata", rdata, 32'h0);
    chk("to.reqoff", 32'(mif.mem_req), 32'd0);
    step();
    chk("to.rdy", 32'(in_ready), 32'd1);

    drive(3'd0, 32'h80, 32'h0);
    chk("rr.req", 32'(mif.mem_req), 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rr.reqoff", 32'(mif.mem_req), 32'd0);
    chk("rr.rdy", 32'(in_ready), 32'd1);
    chk("rr.ov", 32'(out_valid), 32'd0);
    step();
    chk("rr.ov2", 32'(out_valid), 32'd0);
    txn("rr.lw", 3'd0, 32'h84, 32'h0, 32'h0BAD_C0DE, 0,
        4'b1111, 32'h0, 32'h0BAD_C0DE);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
